// File: rtl/systolic_os_result_collector_if.sv
// Result-path bundle between the OS systolic array and its collector.
// Array side drives bottom_out/valids; consumer side drives result_ready.
`ifndef ROWS
`define ROWS 3
`endif
`ifndef COLS
`define COLS 3
`endif

interface systolic_os_result_collector_if #(
   parameter int WORD_SIZE = 16,
   parameter int ROWS      = `ROWS,
   parameter int COLS      = `COLS
);
   logic [COLS*WORD_SIZE-1:0]      bottom_out;
   logic [COLS-1:0]                output_col_valid;
   logic [ROWS*COLS*WORD_SIZE-1:0] result_matrix;
   logic                           result_valid;
   logic                           result_ready;

   modport master (
      output bottom_out,
      output output_col_valid,
      output result_ready,
      input  result_matrix,
      input  result_valid
   );

   modport slave (
      input  bottom_out,
      input  output_col_valid,
      input  result_ready,
      output result_matrix,
      output result_valid
   );
endinterface

// File: rtl/systolic_os_result_collector.sv
// De-serialises the bottom-up OS array row stream into a ROWS x COLS matrix.
// Optional OS_COLLECT_ROWCHK_EN adds a sticky column completion-order check.
`ifndef ROWS
`define ROWS 3
`endif
`ifndef COLS
`define COLS 3
`endif

module systolic_os_result_collector #(
   parameter int WORD_SIZE = 16,
   parameter int ROWS      = `ROWS,
   parameter int COLS      = `COLS
) (
   input  logic clk,
   input  logic rst,
   systolic_os_result_collector_if.slave io,
   input  logic clear,
   output logic busy,
   output logic overflow_err
`ifdef OS_COLLECT_ROWCHK_EN
   ,
   output logic row_order_err
`endif
);

   localparam int PW = $clog2(ROWS) + 1;
   localparam logic [COLS-1:0][PW-1:0] PTR_INIT = {COLS{PW'(ROWS - 1)}};

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD
   } state_e;

   state_e                         state_q, state_d;
   logic [COLS-1:0][PW-1:0]        ptr_q, ptr_d;
   logic [COLS-1:0]                done_q, done_d;
   logic [ROWS*COLS*WORD_SIZE-1:0] mat_q, mat_d;
   logic                           valid_q, valid_d;
   logic                           ovf_q, ovf_d;
   int                             idx;
`ifdef OS_COLLECT_ROWCHK_EN
   logic                           roe_q, roe_d;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = done_q;
      mat_d   = mat_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      idx     = 0;
`ifdef OS_COLLECT_ROWCHK_EN
      roe_d   = roe_q;
`endif
      if (clear) begin
         state_d = IDLE;
         ptr_d   = PTR_INIT;
         done_d  = '0;
         valid_d = 1'b0;
         ovf_d   = 1'b0;
`ifdef OS_COLLECT_ROWCHK_EN
         roe_d   = 1'b0;
`endif
      end else begin
         // Finished columns reject further words; in HOLD every column is done.
         for (int c = 0; c < COLS; c++) begin
            if (io.output_col_valid[c]) begin
               if (done_q[c]) begin
                  ovf_d = 1'b1;
               end else begin
                  idx = int'(ptr_q[c]) * COLS + c;
                  mat_d[idx*WORD_SIZE +: WORD_SIZE] =
                     io.bottom_out[c*WORD_SIZE +: WORD_SIZE];
                  if (ptr_q[c] == '0) begin
                     done_d[c] = 1'b1;
                  end else begin
                     ptr_d[c] = ptr_q[c] - 1'b1;
                  end
               end
            end
         end
`ifdef OS_COLLECT_ROWCHK_EN
         for (int c = 1; c < COLS; c++) begin
            if (done_d[c] && !done_q[c] && !done_d[c-1]) begin
               roe_d = 1'b1;
            end
         end
`endif
         unique case (state_q)
            IDLE: begin
               if (|io.output_col_valid) begin
                  state_d = (&done_d) ? HOLD : COLLECT;
               end
            end
            COLLECT: begin
               if (&done_d) begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (valid_q && io.result_ready) begin
                  state_d = IDLE;
                  ptr_d   = PTR_INIT;
                  done_d  = '0;
                  valid_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
         if (state_d == HOLD && state_q != HOLD) begin
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= PTR_INIT;
         done_q  <= '0;
         mat_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef OS_COLLECT_ROWCHK_EN
         roe_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         mat_q   <= mat_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
`ifdef OS_COLLECT_ROWCHK_EN
         roe_q   <= roe_d;
`endif
      end
   end

   assign io.result_matrix = mat_q;
   assign io.result_valid  = valid_q;
   assign busy             = (state_q == COLLECT);
   assign overflow_err     = ovf_q;
`ifdef OS_COLLECT_ROWCHK_EN
   assign row_order_err    = roe_q;
`endif

endmodule

// File: doc/systolic_os_result_collector.md
Name: systolic_os_result_collector

Overview:
Receiving end of the output-stationary matmul result path. Samples the systolic array's bottom_out bus whenever per-column valid bits are asserted, and de-serialises the bottom-up row stream into a full ROWS x COLS result matrix. Presents the matrix to the downstream consumer with a valid/ready handshake. Sits between the OS matmul control FSM and the BIST comparator / host readback.

Parameters:
WORD_SIZE, 16, bits per matrix element
ROWS, `ROWS, result matrix rows (systolic array rows)
COLS, `COLS, result matrix columns (systolic array columns)

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
bottom_out  input  COLS*WORD_SIZE  array bottom outputs; column c at [(c+1)*WORD_SIZE-1 -: WORD_SIZE]
output_col_valid  input  COLS  bit c=1: column c of bottom_out carries a valid result word this cycle
clear  input  1  synchronous abort: discard partial capture, return to IDLE, clear overflow_err
result_matrix  output  ROWS*COLS*WORD_SIZE  element (r,c) at [(r*COLS+c+1)*WORD_SIZE-1 -: WORD_SIZE]
result_valid  output  1  result_matrix complete and stable
result_ready  input  1  consumer accepts result_matrix
busy  output  1  capture in progress (state COLLECT)
overflow_err  output  1  sticky: valid word arrived with no free slot

Behaviour:
- Reset (rst=0, async): state=IDLE; result_matrix=0, result_valid=0, busy=0, overflow_err=0; all per-column counters reset to ROWS-1.
- Row order: first valid word per column is row ROWS-1, the next is ROWS-2, ..., the last is row 0. Each column keeps an independent row pointer ptr[c] (width $clog2(ROWS)+1) and a done[c] flag.
- IDLE: on posedge with output_col_valid!=0 -> COLLECT, capturing that same beat (no lost first beat). busy=1 from the next cycle.
- COLLECT: for each c with output_col_valid[c]=1 and done[c]=0: write bottom_out column c into element (ptr[c],c); when ptr[c]=0, set done[c], else decrement ptr[c]. Columns can be skewed by any number of cycles. Cycles with no valid bits hold the current state.
- When all done[c] are set (including on the beat that completes the last column) -> HOLD. result_valid=1 on the following cycle (capture-to-valid latency 1 clock after the last word). busy=0.
- HOLD: result_matrix is frozen. result_valid stays at 1 until result_valid&&result_ready. On handshake -> IDLE, counters re-armed, result_valid=0 next cycle. result_matrix keeps its last value until it is overwritten by the next capture.
- Overflow: a valid bit for a column with done[c]=1, in COLLECT or HOLD, discards the word and sets overflow_err. An extra trailing all-valid beat after completion is therefore flagged, never stored.
- Simultaneous handshake in HOLD and new output_col_valid in the same cycle: the handshake is taken, the beat is counted as overflow and is not captured. A new capture starts only from IDLE.
- clear has priority over all other events in any state: -> IDLE, counters re-armed, result_valid=0, overflow_err=0. result_matrix is not zeroed.
- Async reset mid-capture: immediate return to reset values; no partial result is exposed.

Optional Feature:
OS_COLLECT_ROWCHK_EN
- Defined: adds output row_order_err (1 bit, sticky, cleared by rst/clear). It is set if the columns complete out of skew order, i.e. done[c] is set while done[c-1]=0 for any c>0.
- Undefined: the port and its logic are absent. Column completion order is unconstrained.

Test Plan:
- ROWS=COLS=3, all-valid beats [A22,A21,A20], [A12,A11,A10], [A02,A01,A00] on 3 consecutive cycles, result_ready=1 -> result_valid high 1 cycle after the 3rd beat, element(r,c)=Arc, back in IDLE the next cycle.
- Column 2 delayed 2 cycles relative to column 0 (skewed valid bits) -> correct matrix; result_valid rises 1 cycle after column 2's last word.
- Complete capture, then a 4th all-valid beat with result_ready=0 -> overflow_err=1, result_matrix unchanged, result_valid held until result_ready=1.
- Assert clear after 2 of 3 beats -> IDLE, result_valid never rises; a fresh 3-beat stream then captures correctly with overflow_err=0.
- Drop rst low during COLLECT -> all outputs 0 immediately (asynchronous); after release, a full stream produces a correct result.
- With OS_COLLECT_ROWCHK_EN, column 1 completes before column 0 -> row_order_err=1; the matrix is still captured.
